// File: rtl/adc_chain_ctrl.sv
// Sequencer and output FIFO for the sigma-delta decimation chain.
// Holds the chain in reset, discards settling samples, then buffers output.
module adc_chain_ctrl #(
    parameter int DW         = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_CYC    = 8,
    parameter int SETTLE_N   = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          ovf_clr,
    output logic          chain_rstn,
    input  logic          in_vld,
    input  logic [DW-1:0] in_dat,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          ovf,
    output logic [1:0]    state_o
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CNTW-1:0]   count;
    logic              push;
    logic              pop;
    logic              accept;
    logic              drop;

    assign state_o   = state;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    assign push   = en && (state == RUN) && in_vld;
    assign pop    = out_valid && out_ready;
    assign accept = push && ((count < CNTW'(FIFO_DEPTH)) || pop);
    assign drop   = push && !accept;

    // Start-up sequencer: chain reset, settling discard, then run.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            chain_rstn <= 1'b0;
            cnt        <= '0;
        end else if (!en) begin
            state      <= IDLE;
            chain_rstn <= 1'b0;
            cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FLUSH;
                    cnt   <= CW'(RST_CYC - 1);
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        chain_rstn <= 1'b1;
                        cnt        <= CW'(SETTLE_N);
                        if (SETTLE_N == 0) state <= RUN;
                        else               state <= SETTLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (in_vld) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= RUN;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // First-word-fall-through FIFO; flushed whenever en is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (!en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNTW'(accept) - CNTW'(pop);
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        ovf <= 1'b0;
        else if (!en)     ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

endmodule

// File: tb/tb_adc_chain_ctrl.sv
// Randomized bench for adc_chain_ctrl against a queue-based reference model.
// Model tracks elapsed flush cycles and discarded samples directly.
module tb_adc_chain_ctrl;

    localparam int DW    = 20;
    localparam int DEPTH = 4;
    localparam int RSTC  = 8;
    localparam int SETN  = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          ovf_clr;
    logic          chain_rstn;
    logic          in_vld;
    logic [DW-1:0] in_dat;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          ovf;
    logic [1:0]    state_o;

    int n_chk  = 0;
    int n_fail = 0;

    adc_chain_ctrl #(
        .DW(DW), .FIFO_DEPTH(DEPTH), .RST_CYC(RSTC), .SETTLE_N(SETN)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .ovf_clr(ovf_clr),
        .chain_rstn(chain_rstn), .in_vld(in_vld), .in_dat(in_dat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .ovf(ovf), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // reference model
    int            m_phase;
    int            m_flushed;
    int            m_discarded;
    bit            m_crst;
    bit            m_ovf;
    logic [DW-1:0] m_q[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase     = 0;
        m_flushed   = 0;
        m_discarded = 0;
        m_crst      = 0;
        m_ovf       = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit pop;
        bit drop;
        pop  = (m_q.size() > 0) && out_ready;
        drop = 0;
        if (!en) begin
            model_reset();
        end else begin
            if (m_phase == 3 && in_vld) begin
                if (m_q.size() < DEPTH || pop) m_q.push_back(in_dat);
                else drop = 1;
            end
            if (pop) void'(m_q.pop_front());
            if (drop)         m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            if (m_phase == 0) begin
                m_phase   = 1;
                m_flushed = 0;
            end else if (m_phase == 1) begin
                m_flushed++;
                if (m_flushed == RSTC) begin
                    m_crst      = 1;
                    m_discarded = 0;
                    m_phase     = (SETN == 0) ? 3 : 2;
                end
            end else if (m_phase == 2 && in_vld) begin
                m_discarded++;
                if (m_discarded == SETN) m_phase = 3;
            end
        end
    endtask

    task automatic compare(string pfx);
        check({pfx, "state"}, 32'(state_o), 32'(m_phase));
        check({pfx, "chain_rstn"}, 32'(chain_rstn), 32'(m_crst));
        check({pfx, "out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
        check({pfx, "ovf"}, 32'(ovf), 32'(m_ovf));
        if (m_q.size() > 0)
            check({pfx, "out_data"}, 32'(out_data), 32'(m_q[0]));
    endtask

    initial begin
        int rdy_pct;
        int n_rst;
        n_rst     = 0;
        rdy_pct   = 50;
        rstn      = 1'b0;
        en        = 1'b0;
        ovf_clr   = 1'b0;
        in_vld    = 1'b0;
        in_dat    = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare("rst_");
        check("rst_out_data", 32'(out_data), 32'd0);
        rstn = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            compare("");
            rstn = 1'b1;
            if (cyc % 300 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 0;
                    1:       rdy_pct = 30;
                    default: rdy_pct = 90;
                endcase
            end
            if (cyc < 10)       en = 1'b0;
            else if (en)        en = ($urandom_range(0, 399) != 0);
            else                en = ($urandom_range(0, 2) == 0);
            in_vld    = ($urandom_range(0, 2) == 0);
            in_dat    = DW'($urandom);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            model_step();
            if (n_rst < 3 && cyc > 1500 * (n_rst + 1) && m_phase == 2) begin
                @(posedge clk);
                #2;
                rstn = 1'b0;
                #1;
                model_reset();
                compare("async_");
                check("async_out_valid", 32'(out_valid), 32'd0);
                n_rst++;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_chain_ctrl.md
Name: adc_chain_ctrl

Overview:
Sequencer and output buffer for the sigma-delta decimation chain (CIC, CIC compensation, HB1, HB2).
- On enable, it holds the chain in a local reset, then discards the first samples while the filters settle.
- After settling, it forwards decimated 20-bit samples into a small FIFO with a valid/ready handshake to the downstream consumer.
- It reports overflow (dropped samples) and its current state.

Parameters:
DW, 20, sample width (matches chain output width)
FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2
RST_CYC, 8, clk cycles chain_rstn is held low on each start
SETTLE_N, 16, number of chain output strobes discarded after reset release; range 0..255

Ports:
clk  input  1  system clock, shared with filter chain
rstn  input  1  asynchronous active-low reset
en  input  1  level enable; 1 = acquire, 0 = stop and flush
ovf_clr  input  1  single-cycle pulse that clears sticky ovf
chain_rstn  output  1  active-low reset to filter chain (ANDed with rstn at top level)
in_vld  input  1  chain output strobe (HB2 clk_vld_out), one-cycle pulse
in_dat  input  DW  chain output sample, signed, valid when in_vld=1
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head when out_valid & out_ready
out_data  output  DW  FIFO head sample, signed
ovf  output  1  sticky; a sample was dropped because the FIFO was full
state_o  output  2  current state: 0 IDLE, 1 FLUSH, 2 SETTLE, 3 RUN

Behaviour:
Reset (rstn=0, async), all outputs:
- state=IDLE, chain_rstn=0, out_valid=0, out_data=0, ovf=0.
- FIFO empty; counters cleared.

FSM transitions (registered, evaluated each clk):
- IDLE: chain_rstn=0. When en=1, go to FLUSH and load rst counter with RST_CYC-1.
- FLUSH: chain_rstn=0; counter decrements.
  - At count 0, go to SETTLE, load settle counter with SETTLE_N, and drive chain_rstn=1 from the next cycle.
  - If SETTLE_N=0, go directly to RUN.
- SETTLE: chain_rstn=1. Each in_vld decrements the settle counter; the sample is discarded and not written.
  - Go to RUN on the in_vld that brings the counter to 0.
  - That sample is also discarded, so exactly SETTLE_N samples are dropped.
- RUN: chain_rstn=1. Each in_vld pushes in_dat into the FIFO.
- en=0 in any state: go to IDLE on the next edge.
  - chain_rstn=0 from that edge.
  - FIFO flushed (out_valid=0 next cycle); ovf cleared.
  - A pop in the same cycle as en falling is still honoured on the interface; its data is considered consumed.
- en re-asserted in the cycle after IDLE entry: a full FLUSH/SETTLE sequence runs again. There is no shortcut.

FIFO behaviour:
- First-word-fall-through.
- A sample pushed at edge t appears on out_data with out_valid=1 after edge t when the FIFO was empty. Push-to-valid latency is 1 cycle.
- Pop occurs when out_valid & out_ready at an edge. out_data/out_valid stay stable while out_valid=1 and out_ready=0.
- Push is accepted when count<FIFO_DEPTH, or when count=FIFO_DEPTH and a pop happens in the same cycle (simultaneous push+pop when full is lossless).
- Otherwise the push is dropped, ovf is set at that edge, and FIFO contents are unchanged.
- Simultaneous push and pop at count=0 is impossible: out_valid=0, so there is no pop, and the push is accepted.
- Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.

Other rules:
- ovf: sticky. Cleared by ovf_clr or entry to IDLE. If set and clear happen in the same cycle, set wins.
- in_vld is ignored in IDLE and FLUSH.
- No arithmetic is performed on data; samples pass through bit-exact, signed, DW bits.

Test Plan:
- Reset then en=1, in_vld pulses every 10 cycles with in_dat = 1,2,3,... -> chain_rstn low for 8 cycles after en, samples 1..16 discarded, first out_data=17 with out_valid one cycle after its in_vld.
- RUN with out_ready=0, push 5 samples (100..104) -> FIFO holds 100..103, 104 dropped, ovf=1; then out_ready=1 -> outputs 100,101,102,103 in order, out_valid falls after 103.
- FIFO full (4 entries), out_ready=1 and in_vld in the same cycle -> push accepted, ovf stays 0, order preserved.
- ovf=1, ovf_clr pulse coinciding with a dropped push -> ovf remains 1; next ovf_clr alone -> ovf=0.
- en drops in RUN with 3 entries queued -> next cycle state=IDLE, chain_rstn=0, out_valid=0; en re-asserted -> full 8-cycle FLUSH plus 16-sample SETTLE before new data appears.
- rstn asserted mid-SETTLE (asynchronous, between edges) -> immediately state=IDLE, chain_rstn=0, out_valid=0, ovf=0; with SETTLE_N=0 build, data forwarded from the first post-flush in_vld.
